// File: rtl/timer_arbiter.sv
// timer_arbiter: one programmable interval timer shared round-robin among N
// requesters. Each owner gets LEN ticks of a selectable time base, then a
// one-cycle done pulse. Outputs grant, done and busy are all registered.
module timer_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned DIV_BAUD = 5206,
  parameter int unsigned DIV_10K  = 5000,
  parameter int unsigned DIV_1K   = 50000,
  parameter int unsigned DIV_100K = 500
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [2*N-1:0]     sel,
  input  logic [LEN_W*N-1:0] len,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       done,
  output logic               busy
);

  localparam int unsigned PTR_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DIV_M01 = (DIV_BAUD > DIV_10K)  ? DIV_BAUD : DIV_10K;
  localparam int unsigned DIV_M23 = (DIV_1K   > DIV_100K) ? DIV_1K   : DIV_100K;
  localparam int unsigned DIV_MAX = (DIV_M01 > DIV_M23) ? DIV_M01 : DIV_M23;
  localparam int unsigned PCNT_W  = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned CAND_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [1:0]          sel_q, sel_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [N-1:0]        done_q, done_d;
  logic                busy_q, busy_d;

  logic [1:0]          sel_a [N];
  logic [LEN_W-1:0]    len_a [N];
  logic [CAND_W-1:0]   cand;
  logic                pick_found;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    ptr_next;
  logic [PCNT_W-1:0]   div_m1;
  logic                owner_req;

  // Split the flat per-requester select and length buses into arrays.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      sel_a[i] = sel[2*i +: 2];
      len_a[i] = len[LEN_W*i +: LEN_W];
    end
  end

  // Round-robin pick: first set request searching ptr, ptr+1, ... modulo N.
  always_comb begin
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + CAND_W'(k);
      if (cand >= CAND_W'(N)) begin
        cand = cand - CAND_W'(N);
      end
      if (!pick_found && req[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Pointer value after the current owner releases: owner + 1 modulo N.
  always_comb begin
    ptr_next = (owner_q == PTR_W'(N - 1)) ? '0 : owner_q + PTR_W'(1);
  end

  // Terminal prescaler count for the captured time base.
  always_comb begin
    unique case (sel_q)
      2'd0:    div_m1 = PCNT_W'(DIV_BAUD - 1);
      2'd1:    div_m1 = PCNT_W'(DIV_10K - 1);
      2'd2:    div_m1 = PCNT_W'(DIV_1K - 1);
      default: div_m1 = PCNT_W'(DIV_100K - 1);
    endcase
  end

  assign owner_req = req[owner_q];

  // Next-state and registered-output logic for the arbitration/timer FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    pcnt_d  = pcnt_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_found) begin
          owner_d = pick_idx;
          sel_d   = sel_a[pick_idx];
          rem_d   = len_a[pick_idx];
          pcnt_d  = '0;
          grant_d = N'(1) << pick_idx;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!owner_req) begin
          // Owner withdrew before the interval started: release silently.
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end else if (rem_q == '0) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          pcnt_d  = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!owner_req) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end else if (pcnt_q == div_m1) begin
          pcnt_d = '0;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            done_d  = grant_q;
            state_d = S_DONE;
          end
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end

      S_DONE: begin
        // done is high during this state; the owner drops to lowest priority.
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end

      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything including the pointer.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
      pcnt_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      pcnt_q  <= pcnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: scenario tasks push expected grant/done events to a
// scoreboard queue; a negedge monitor pops and checks them as the DUT emits them.
module tb_timer_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned LEN_W = 16;

  logic               clk_50M;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [2*N-1:0]     sel;
  logic [LEN_W*N-1:0] len;
  logic [N-1:0]       grant;
  logic [N-1:0]       done;
  logic               busy;

  timer_arbiter #(
    .N(N), .LEN_W(LEN_W), .DIV_BAUD(5206), .DIV_10K(5000), .DIV_1K(50000), .DIV_100K(500)
  ) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .req     (req),
    .sel     (sel),
    .len     (len),
    .grant   (grant),
    .done    (done),
    .busy    (busy)
  );

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  // Expected event: a grant rise (lat = cycles since grant last dropped, -1 = any)
  // or a done pulse (lat = cycles since the grant rose).
  typedef struct {
    bit           is_done;
    logic [N-1:0] vec;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           grant_cyc = 0;
  int           drop_cyc = 0;
  logic [N-1:0] prev_grant = '0;

  always @(posedge clk_50M) cyc++;

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk_50M) begin
    exp_t e;
    if (grant !== prev_grant && grant !== '0) begin
      grant_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got grant=%b at cycle %0d, none expected", grant, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done || e.vec !== grant || (e.lat >= 0 && (cyc - drop_cyc) != e.lat)) begin
          errors++;
          $display("FAIL grant_event: got grant=%b gap=%0d, expected %s vec=%b gap=%0d",
                   grant, cyc - drop_cyc, e.is_done ? "done" : "grant", e.vec, e.lat);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_with_grant: got busy=%b, expected 1", busy);
      end
    end
    if (done !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=%b at cycle %0d, none expected", done, cyc);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_done || e.vec !== done || (cyc - grant_cyc) != e.lat) begin
          errors++;
          $display("FAIL done_event: got done=%b latency=%0d, expected %s vec=%b latency=%0d",
                   done, cyc - grant_cyc, e.is_done ? "done" : "grant", e.vec, e.lat);
        end
      end
      checks++;
      if (grant !== done) begin
        errors++;
        $display("FAIL grant_during_done: got grant=%b, expected %b", grant, done);
      end
    end
    if (grant === '0 && prev_grant !== '0) drop_cyc = cyc;
    prev_grant = grant;
  end

  function automatic exp_t mk(input bit d, input logic [N-1:0] v, input int l);
    exp_t e;
    e.is_done = d;
    e.vec     = v;
    e.lat     = l;
    return e;
  endfunction

  task automatic set_cfg(input int i, input logic [1:0] s, input logic [LEN_W-1:0] l);
    sel[2*i +: 2]         = s;
    len[LEN_W*i +: LEN_W] = l;
  endtask

  // Wait (bounded) for done[i]; returns at the negedge where it is seen.
  task automatic wait_done(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_50M);
      if (done[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_50M);
    req   = '0;
    rst_n = 1'b0;
    @(negedge clk_50M);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk_50M);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d events outstanding, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    sel   = '0;
    len   = '0;
    #5;
    checks++;
    if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b, expected 0", grant); end
    checks++;
    if (done !== '0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    @(posedge clk_50M); #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got grant=%b busy=%b, expected 0/0", grant, busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    set_cfg(0, 2'd3, 16'd4);
    exp_q.push_back(mk(0, 4'b0001, -1));
    exp_q.push_back(mk(1, 4'b0001, 2001));
    req = 4'b0001;
    @(posedge clk_50M); #1;
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant_edge: got grant=%b busy=%b, expected 0001/1", grant, busy);
    end
    wait_done(0, 2100, ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got no done[0], expected pulse"); end
    @(posedge clk_50M); #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got grant=%b busy=%b, expected 0000/0", grant, busy);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    set_cfg(0, 2'd3, 16'd2);
    set_cfg(2, 2'd3, 16'd2);
    exp_q.push_back(mk(0, 4'b0001, -1));
    exp_q.push_back(mk(1, 4'b0001, 1001));
    exp_q.push_back(mk(0, 4'b0100, 1));
    exp_q.push_back(mk(1, 4'b0100, 1001));
    exp_q.push_back(mk(0, 4'b0001, 1));
    exp_q.push_back(mk(1, 4'b0001, 1001));
    req = 4'b0101;
    wait_done(0, 1100, ok);
    req[0] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got no done[0], expected pulse"); end
    repeat (200) @(negedge clk_50M);
    req[0] = 1'b1;
    wait_done(2, 1100, ok);
    req[2] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_second_timeout: got no done[2], expected pulse"); end
    wait_done(0, 1100, ok);
    req[0] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_third_timeout: got no done[0], expected pulse"); end
    drain("b2b");
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [N-1:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) set_cfg(i, 2'd3, 16'd1);
    for (int k = 0; k < 5; k++) begin
      v = 4'b0001 << (k % 4);
      exp_q.push_back(mk(0, v, (k == 0) ? -1 : 1));
      exp_q.push_back(mk(1, v, 501));
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(k % 4, 600, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_timeout_%0d: got no done[%0d], expected pulse", k, k % 4); end
    end
    req = '0;
    drain("rr");
  endtask

  task automatic test_len_bounds();
    bit ok;
    do_reset();
    set_cfg(0, 2'd3, 16'd0);
    exp_q.push_back(mk(0, 4'b0001, -1));
    exp_q.push_back(mk(1, 4'b0001, 1));
    req = 4'b0001;
    wait_done(0, 10, ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL len0_timeout: got no done[0], expected pulse"); end
    repeat (3) @(negedge clk_50M);
    set_cfg(0, 2'd0, 16'd3);
    exp_q.push_back(mk(0, 4'b0001, -1));
    exp_q.push_back(mk(1, 4'b0001, 15619));
    req = 4'b0001;
    repeat (10) @(negedge clk_50M);
    set_cfg(0, 2'd3, 16'd0);
    wait_done(0, 16000, ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL baud_timeout: got no done[0], expected pulse"); end
    drain("len_bounds");
  endtask

  task automatic test_abort();
    bit ok;
    do_reset();
    set_cfg(1, 2'd3, 16'd5);
    set_cfg(2, 2'd3, 16'd1);
    exp_q.push_back(mk(0, 4'b0010, -1));
    exp_q.push_back(mk(0, 4'b0100, 1));
    exp_q.push_back(mk(1, 4'b0100, 501));
    req = 4'b0110;
    repeat (100) @(negedge clk_50M);
    req[1] = 1'b0;
    @(posedge clk_50M); #1;
    checks++;
    if (grant !== '0 || done !== '0) begin
      errors++;
      $display("FAIL abort_release: got grant=%b done=%b, expected 0000/0000", grant, done);
    end
    wait_done(2, 600, ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_pending_timeout: got no done[2], expected pulse"); end
    drain("abort");
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    set_cfg(1, 2'd2, 16'd1);
    exp_q.push_back(mk(0, 4'b0010, -1));
    req = 4'b0010;
    repeat (1000) @(negedge clk_50M);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0) begin errors++; $display("FAIL areset_grant: got %b, expected 0", grant); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b, expected 0", busy); end
    checks++;
    if (done !== '0) begin errors++; $display("FAIL areset_done: got %b, expected 0", done); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL areset_first_grant: got %0d events outstanding, expected 0", exp_q.size());
    end
    @(negedge clk_50M);
    exp_q.push_back(mk(0, 4'b0010, -1));
    exp_q.push_back(mk(1, 4'b0010, 50001));
    rst_n = 1'b1;
    wait_done(1, 50100, ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL areset_restart_timeout: got no done[1], expected pulse"); end
    drain("areset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_len_bounds();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
